muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit and HI/LO register file for MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the single-cycle ALU in the execute stage.
- The datapath starts an operation with a one-cycle start pulse and stalls on busy.
- Results are read from hi/lo, which MFHI/MFLO forward.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_sign_fix.sv | 11 +
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: multiply/divide op codes and FSM state codes.
// Imported by the HI/LO multiply/divide unit and its helpers.
package cpu_types_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } muldiv_op_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Ops that run the 32-iteration datapath.
  function automatic logic md_is_iter(logic [2:0] op);
    return op < 3'd4;
  endfunction

  function automatic logic md_is_signed(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Bundle for the multiply/divide unit: start/op/operands in, status and HI/LO out.
// Modports: muldiv (the unit side) and tb (the driver side).
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] portA;
  logic [WIDTH-1:0] portB;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport muldiv (
    input  start, op, portA, portB,
    output busy, done, div0, hi, lo
  );

  modport tb (
    output start, op, portA, portB,
    input  busy, done, div0, hi, lo
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: magnitude on latch, sign on writeback.
// Ports: val (N), neg (1) -> res (N).
module muldiv_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] val,
  input  logic         neg,
  output logic [N-1:0] res
);
  assign res = neg ? (~val) + {{(N-1){1'b0}}, 1'b1} : val;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU and HI/LO file (MTHI/MTLO), 1 bit per cycle.
// Ports: CLK, RST, start, op, portA, portB -> busy, done, div0, hi, lo.
module muldiv_unit
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int AW = 2 * WIDTH + 1;

  logic [1:0]       state;
  logic [CNTW-1:0]  cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] raw_a;

  logic             accept;
  logic             last;
  logic             sgn_in;
  logic [WIDTH-1:0] mag_a_in;
  logic [WIDTH-1:0] mag_b_in;

  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign accept = start && (state != ST_RUN);
  assign last   = (cnt == CNTW'(WIDTH - 1));
  assign sgn_in = md_is_signed(op);

  muldiv_sign_fix #(.N(WIDTH)) u_fix_a (
    .val (portA),
    .neg (sgn_in & portA[WIDTH-1]),
    .res (mag_a_in)
  );

  muldiv_sign_fix #(.N(WIDTH)) u_fix_b (
    .val (portB),
    .neg (sgn_in & portB[WIDTH-1]),
    .res (mag_b_in)
  );

  // Shift-add multiply: add multiplicand into the upper half, shift right.
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  assign mul_sum  = acc[AW-1:WIDTH] + (acc[0] ? {1'b0, mag_b} : '0);
  assign mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: shift left, trial-subtract, keep if non-negative.
  logic [AW-1:0]    sh;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [AW-1:0]    div_next;
  assign sh       = {acc[AW-2:0], 1'b0};
  assign trial    = sh[AW-1:WIDTH] - {1'b0, mag_b};
  assign q_bit    = ~trial[WIDTH];
  assign div_next = {q_bit ? trial : sh[AW-1:WIDTH],
                     sh[WIDTH-1:1], q_bit};

  logic [AW-1:0]    acc_next;
  assign acc_next = is_div ? div_next : mul_next;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               unused_acc_top;
  assign unused_acc_top = acc_next[AW-1];

  muldiv_sign_fix #(.N(2*WIDTH)) u_fix_p (
    .val (acc_next[2*WIDTH-1:0]),
    .neg (neg_q),
    .res (prod)
  );

  muldiv_sign_fix #(.N(WIDTH)) u_fix_q (
    .val (acc_next[WIDTH-1:0]),
    .neg (neg_q),
    .res (quo)
  );

  muldiv_sign_fix #(.N(WIDTH)) u_fix_r (
    .val (acc_next[2*WIDTH-1:WIDTH]),
    .neg (neg_r),
    .res (rem)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc    <= '0;
      mag_b  <= '0;
      raw_a  <= '0;
      div0   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      if (md_is_iter(op)) begin
        state  <= ST_RUN;
        cnt    <= '0;
        is_div <= op[1];
        neg_q  <= sgn_in & (portA[WIDTH-1] ^ portB[WIDTH-1]);
        neg_r  <= sgn_in & portA[WIDTH-1];
        acc    <= {{(WIDTH+1){1'b0}}, mag_a_in};
        mag_b  <= mag_b_in;
        raw_a  <= portA;
      end else begin
        state <= ST_IDLE;
        if (op == MD_MTHI) hi <= portA;
        if (op == MD_MTLO) lo <= portA;
      end
    end else if (state == ST_RUN) begin
      acc <= acc_next;
      cnt <= cnt + CNTW'(1);
      if (last) begin
        state <= ST_DONE;
        if (!is_div) begin
          hi <= prod[2*WIDTH-1:WIDTH];
          lo <= prod[WIDTH-1:0];
        end else if (mag_b == '0) begin
          hi   <= raw_a;
          lo   <= '1;
          div0 <= 1'b1;
        end else begin
          hi   <= rem;
          lo   <= quo;
          div0 <= 1'b0;
        end
      end
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus handshake/reset sequences.
// Expected HI/LO values are hand-computed constants.
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] portA = '0;
  logic [31:0] portB = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;
  logic        cur_div0 = 1'b0;

  always #5 CLK = ~CLK;

  muldiv_unit dut (
    .CLK   (CLK),
    .RST   (RST),
    .start (start),
    .op    (op),
    .portA (portA),
    .portB (portB),
    .busy  (busy),
    .done  (done),
    .div0  (div0),
    .hi    (hi),
    .lo    (lo)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive a request for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge CLK);
    start = 1'b1;
    op    = o;
    portA = a;
    portB = b;
    @(posedge CLK);
    #1;
    start = 1'b0;
    op    = 3'd7;
    portA = $urandom;
    portB = $urandom;
  endtask

  // Follows edges E1..E32; optionally pokes a start in mid-RUN.
  task automatic run_wait(input string name, input bit inject);
    bit ok = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      @(posedge CLK);
      #1;
      if (k < 32)
        ok &= busy && !done && hi === cur_hi && lo === cur_lo;
      else
        ok &= !busy && done;
      if (inject && k == 10) begin
        start = 1'b1;
        op    = MD_MULT;
        portA = 32'd7;
        portB = 32'd9;
      end
      if (inject && k == 11) start = 1'b0;
    end
    chk({name, " timing"}, 32'(ok), 32'd1);
  endtask

  task automatic check_result(input string name, input logic [31:0] eh,
                              input logic [31:0] el, input logic ed);
    chk({name, " hi"}, hi, eh);
    chk({name, " lo"}, lo, el);
    chk({name, " div0"}, 32'(div0), 32'(ed));
    cur_hi   = eh;
    cur_lo   = el;
    cur_div0 = ed;
  endtask

  task automatic check_idle(input string name);
    @(posedge CLK);
    #1;
    chk({name, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{"multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{"mult_m3x7", MD_MULT, 32'hFFFFFFFD, 32'd7,
                 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[2]  = '{"div_m7d2", MD_DIV, 32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{"divu_100d0", MD_DIVU, 32'd100, 32'd0,
                 32'h00000064, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{"div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF,
                 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{"divu_100d7", MD_DIVU, 32'd100, 32'd7,
                 32'd2, 32'd14, 1'b0};
    vecs[6]  = '{"div_7dm2", MD_DIV, 32'd7, 32'hFFFFFFFE,
                 32'd1, 32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{"mult_min_sq", MD_MULT, 32'h80000000, 32'h80000000,
                 32'h40000000, 32'h00000000, 1'b0};
    vecs[8]  = '{"mult_min_x1", MD_MULT, 32'h80000000, 32'd1,
                 32'hFFFFFFFF, 32'h80000000, 1'b0};
    vecs[9]  = '{"divu_big", MD_DIVU, 32'hFFFFFFFF, 32'h10,
                 32'h0000000F, 32'h0FFFFFFF, 1'b0};
    vecs[10] = '{"mult_m1sq", MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'd0, 32'd1, 1'b0};
    vecs[11] = '{"div_m8d0", MD_DIV, 32'hFFFFFFF8, 32'd0,
                 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[12] = '{"multu_keep0", MD_MULTU, 32'd2, 32'd3,
                 32'd0, 32'd6, 1'b1};
    vecs[13] = '{"div_m9dm4", MD_DIV, 32'hFFFFFFF7, 32'hFFFFFFFC,
                 32'hFFFFFFFF, 32'd2, 1'b0};
    vecs[14] = '{"multu_1e5", MD_MULTU, 32'd100000, 32'd100000,
                 32'h00000002, 32'h540BE400, 1'b0};

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("reset state", {27'd0, busy, done, div0, 2'b00}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      chk({vecs[i].name, " busy0"}, 32'(busy), 32'd1);
      run_wait(vecs[i].name, 1'b0);
      check_result(vecs[i].name, vecs[i].hi, vecs[i].lo, vecs[i].div0);
      check_idle(vecs[i].name);
    end

    // Start during RUN is ignored.
    issue(MD_MULTU, 32'd3, 32'd5);
    run_wait("ignore_start", 1'b1);
    check_result("ignore_start", 32'd0, 32'd15, cur_div0);
    check_idle("ignore_start");

    // Start in DONE issues with no bubble.
    issue(MD_MULTU, 32'd4, 32'd5);
    run_wait("b2b_first", 1'b0);
    check_result("b2b_first", 32'd0, 32'd20, cur_div0);
    issue(MD_DIVU, 32'd100, 32'd7);
    chk("b2b no bubble", 32'(busy), 32'd1);
    run_wait("b2b_second", 1'b0);
    check_result("b2b_second", 32'd2, 32'd14, 1'b0);
    check_idle("b2b_second");

    // MTHI / MTLO / reserved code.
    issue(MD_MTHI, 32'h12345678, 32'd0);
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi lo", lo, cur_lo);
    chk("mthi flags", {30'd0, busy, done}, 32'd0);
    cur_hi = 32'h12345678;
    check_idle("mthi");
    issue(MD_MTLO, 32'hCAFEF00D, 32'd0);
    chk("mtlo lo", lo, 32'hCAFEF00D);
    chk("mtlo hi", hi, cur_hi);
    chk("mtlo div0", 32'(div0), 32'(cur_div0));
    cur_lo = 32'hCAFEF00D;
    check_idle("mtlo");
    issue(3'd6, 32'hDEADBEEF, 32'd1);
    chk("nop hi", hi, cur_hi);
    chk("nop lo", lo, cur_lo);
    check_idle("nop");

    // Reset mid-operation.
    issue(MD_DIVU, 32'd1000, 32'd3);
    repeat (10) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("rst_mid flags", {29'd0, busy, done, div0}, 32'd0);
    chk("rst_mid hi", hi, 32'd0);
    chk("rst_mid lo", lo, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    begin
      bit quiet = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(posedge CLK);
        #1;
        quiet &= !busy && !done;
      end
      chk("rst_mid quiet", 32'(quiet), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
